vc_arbiter: RTL and testbench

Arbiter and sequencer between the two virtual-channel FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1) of the QoS datapath. It pops one word per cycle from the winning VC, using strict priority for VC0 with a starvation guard for VC1. It steers each word to D0 or D1 by its destination bit and stops issuing pops while either destination signals pause. It is enabled by the init FSM's active state and reports its own idle/drain status back.

---
 rtl/vc_arb_pkg.sv | 19 +
 rtl/vc_arb_starve_cnt.sv | 34 +++
 rtl/vc_arbiter.sv | 119 +++++++++++
 tb/tb_vc_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vc_arb_pkg.sv
// Shared definitions for the VC arbiter: FSM encoding, default geometry,
// and the starvation counter width helper.
package vc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    localparam int BW_DEFAULT         = 6;
    localparam int DEST_BIT_DEFAULT   = BW_DEFAULT - 2;
    localparam int STARVE_MAX_DEFAULT = 4;

    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/vc_arb_starve_cnt.sv
// Starvation guard for VC1: counts VC0 grants taken while VC1 waits and
// flags when VC1 must be served next.
module vc_arb_starve_cnt
    import vc_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic clk,
    input  logic reset_L,
    input  logic grant_vc0,
    input  logic grant_vc1,
    input  logic vc1_empty,
    output logic force_vc1
);

    localparam int CNT_W = cnt_width(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;

    // The count only means something while VC1 actually has data waiting.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            starve_cnt <= '0;
        end else if (vc1_empty || grant_vc1) begin
            starve_cnt <= '0;
        end else if (grant_vc0 && (starve_cnt != CNT_MAX)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign force_vc1 = (starve_cnt == CNT_MAX);

endmodule

// File: rtl/vc_arbiter.sv
// Pops one word per cycle from VC0/VC1 (VC0 priority with VC1 starvation
// guard) and pushes it two cycles later to D0 or D1 by its destination bit.
module vc_arbiter
    import vc_arb_pkg::*;
#(
    parameter int BW         = BW_DEFAULT,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT,
    parameter int DEST_BIT   = BW - 2
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic          enable,
    input  logic          vc0_empty,
    input  logic          vc1_empty,
    input  logic [BW-1:0] vc0_data,
    input  logic [BW-1:0] vc1_data,
    input  logic          d0_pause,
    input  logic          d1_pause,
    output logic          vc0_rd,
    output logic          vc1_rd,
    output logic          d0_wr,
    output logic          d1_wr,
    output logic [BW-1:0] d_data_out,
    output logic          idle_out,
    output logic          grant_vc1_forced
);

    arb_state_t    state;
    logic          pop_ok;
    logic          force_vc1;
    logic          grant_vc0;
    logic          grant_vc1;
    logic          vld_p0;
    logic          src_p0;
    logic          vld_p1;
    logic [BW-1:0] data_p1;

    // Destination is unknown until the word is read, so either pause blocks.
    always_comb begin
        pop_ok    = (state == RUN) && !d0_pause && !d1_pause;
        grant_vc1 = pop_ok && !vc1_empty && (vc0_empty || force_vc1);
        grant_vc0 = pop_ok && !vc0_empty && !grant_vc1;
    end

    assign vc0_rd           = grant_vc0;
    assign vc1_rd           = grant_vc1;
    assign grant_vc1_forced = grant_vc1 && !vc0_empty;

    vc_arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk       (clk),
        .reset_L   (reset_L),
        .grant_vc0 (grant_vc0),
        .grant_vc1 (grant_vc1),
        .vc1_empty (vc1_empty),
        .force_vc1 (force_vc1)
    );

    // DRAIN leaves once nothing sits in the first stage: the word in the
    // output stage is pushed this cycle, so idle_out rises right after it.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state    <= IDLE;
            idle_out <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state    <= RUN;
                        idle_out <= 1'b0;
                    end
                end
                RUN: begin
                    if (!enable) state <= DRAIN;
                end
                DRAIN: begin
                    if (enable) begin
                        state <= RUN;
                    end else if (!vld_p0) begin
                        state    <= IDLE;
                        idle_out <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    idle_out <= 1'b1;
                end
            endcase
        end
    end

    // Stage p0: remember that a pop was issued and from which VC.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            vld_p0 <= 1'b0;
            src_p0 <= 1'b0;
        end else begin
            vld_p0 <= grant_vc0 || grant_vc1;
            src_p0 <= grant_vc1;
        end
    end

    // Stage p1: capture the FIFO read data, now valid, for the push.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) data_p1 <= src_p0 ? vc1_data : vc0_data;
        end
    end

    assign d0_wr      = vld_p1 && !data_p1[DEST_BIT];
    assign d1_wr      = vld_p1 &&  data_p1[DEST_BIT];
    assign d_data_out = data_p1;

endmodule

// File: tb/tb_vc_arbiter.sv
// Directed bench for vc_arbiter with simple VC FIFO models feeding it.
module tb_vc_arbiter;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       enable;
    logic       vc0_empty, vc1_empty;
    logic [5:0] vc0_data = '0;
    logic [5:0] vc1_data = '0;
    logic       d0_pause, d1_pause;
    logic       vc0_rd, vc1_rd, d0_wr, d1_wr;
    logic [5:0] d_data_out;
    logic       idle_out, grant_vc1_forced;

    int checks = 0;
    int errors = 0;

    logic [5:0] mem0 [64];
    logic [5:0] mem1 [64];
    int wp0 = 0, rp0 = 0, wp1 = 0, rp1 = 0;

    always #5 clk = ~clk;

    vc_arbiter dut (
        .clk              (clk),
        .reset_L          (reset_L),
        .enable           (enable),
        .vc0_empty        (vc0_empty),
        .vc1_empty        (vc1_empty),
        .vc0_data         (vc0_data),
        .vc1_data         (vc1_data),
        .d0_pause         (d0_pause),
        .d1_pause         (d1_pause),
        .vc0_rd           (vc0_rd),
        .vc1_rd           (vc1_rd),
        .d0_wr            (d0_wr),
        .d1_wr            (d1_wr),
        .d_data_out       (d_data_out),
        .idle_out         (idle_out),
        .grant_vc1_forced (grant_vc1_forced)
    );

    // VC FIFO models: read data appears the cycle after the rd strobe.
    assign vc0_empty = (rp0 == wp0);
    assign vc1_empty = (rp1 == wp1);

    always @(posedge clk) begin
        if (vc0_rd) begin
            vc0_data <= mem0[rp0];
            rp0      <= rp0 + 1;
        end
        if (vc1_rd) begin
            vc1_data <= mem1[rp1];
            rp1      <= rp1 + 1;
        end
    end

    task automatic load0(input logic [5:0] w);
        mem0[wp0] = w;
        wp0 = wp0 + 1;
    endtask

    task automatic load1(input logic [5:0] w);
        mem1[wp1] = w;
        wp1 = wp1 + 1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    int g_tab [20] = '{0,0,0,0,1,0,0,0,0,1,0,0,1,1,1,1,1,1,1,1};
    int f_tab [20] = '{0,0,0,0,1,0,0,0,0,1,0,0,0,0,0,0,0,0,0,0};

    initial begin
        int n0;
        int n1;
        int g;
        logic [5:0] exp_word;

        reset_L  = 1'b0;
        enable   = 1'b1;
        d0_pause = 1'b0;
        d1_pause = 1'b0;
        load0(6'h05);
        load0(6'h15);
        load0(6'h25);

        // Reset held with VC0 non-empty and enable high
        cyc(); #1;
        chk("rst_vc0_rd", vc0_rd, 0);
        chk("rst_vc1_rd", vc1_rd, 0);
        chk("rst_d0_wr", d0_wr, 0);
        chk("rst_d1_wr", d1_wr, 0);
        chk("rst_data", d_data_out, 0);
        chk("rst_idle", idle_out, 1);
        chk("rst_forced", grant_vc1_forced, 0);
        cyc(); reset_L = 1'b1;

        // VC0 only: three pops, pushes steered by bit 4
        cyc(); #1;
        chk("b1_rd", vc0_rd, 1);
        chk("b1_idle", idle_out, 0);
        chk("b1_wr", d0_wr | d1_wr, 0);
        cyc(); #1;
        chk("b2_rd", vc0_rd, 1);
        cyc(); #1;
        chk("b3_rd", vc0_rd, 1);
        chk("b3_d0_wr", d0_wr, 1);
        chk("b3_data", d_data_out, 8'h05);
        cyc(); #1;
        chk("b4_rd", vc0_rd, 0);
        chk("b4_d1_wr", d1_wr, 1);
        chk("b4_d0_wr", d0_wr, 0);
        chk("b4_data", d_data_out, 8'h15);
        cyc(); #1;
        chk("b5_d0_wr", d0_wr, 1);
        chk("b5_data", d_data_out, 8'h25);
        cyc(); #1;
        chk("b6_wr", d0_wr | d1_wr, 0);

        // Both VCs hold 10 words: VC0 x4, forced VC1, VC0 x4, forced VC1, ...
        cyc();
        for (int i = 0; i < 10; i++) begin
            load0(6'(i));
            load1(6'(8'h30 + i));
        end
        n0 = 0;
        n1 = 0;
        for (int k = 0; k < 22; k++) begin
            if (k > 0) cyc();
            #1;
            if (k < 20) begin
                g = g_tab[k];
                chk($sformatf("sv_vc0_rd%0d", k), vc0_rd, (g == 0) ? 8'd1 : 8'd0);
                chk($sformatf("sv_vc1_rd%0d", k), vc1_rd, (g == 1) ? 8'd1 : 8'd0);
                chk($sformatf("sv_forced%0d", k), grant_vc1_forced, 8'(f_tab[k]));
            end else begin
                chk($sformatf("sv_rd%0d", k), vc0_rd | vc1_rd, 0);
            end
            if (k >= 2) begin
                g = g_tab[k-2];
                chk($sformatf("sv_d0_wr%0d", k), d0_wr, (g == 0) ? 8'd1 : 8'd0);
                chk($sformatf("sv_d1_wr%0d", k), d1_wr, (g == 1) ? 8'd1 : 8'd0);
                if (g == 0) begin
                    exp_word = 6'(n0);
                    n0++;
                end else begin
                    exp_word = 6'(8'h30 + n1);
                    n1++;
                end
                chk($sformatf("sv_data%0d", k), d_data_out, 8'(exp_word));
            end else begin
                chk($sformatf("sv_wr%0d", k), d0_wr | d1_wr, 0);
            end
        end

        // Pause mid-burst: pops stop at once, in-flight words still land
        cyc();
        for (int i = 1; i <= 6; i++) load0(6'(i));
        #1;
        chk("p1_rd", vc0_rd, 1);
        cyc(); #1;
        chk("p2_rd", vc0_rd, 1);
        cyc(); d1_pause = 1'b1; #1;
        chk("p3_rd", vc0_rd, 0);
        chk("p3_d0_wr", d0_wr, 1);
        chk("p3_data", d_data_out, 8'h01);
        cyc(); #1;
        chk("p4_rd", vc0_rd, 0);
        chk("p4_d0_wr", d0_wr, 1);
        chk("p4_data", d_data_out, 8'h02);
        cyc(); #1;
        chk("p5_rd", vc0_rd, 0);
        chk("p5_wr", d0_wr | d1_wr, 0);
        cyc(); d1_pause = 1'b0; #1;
        chk("p6_rd", vc0_rd, 1);
        cyc(); #1;
        chk("p7_rd", vc0_rd, 1);
        chk("p7_wr", d0_wr | d1_wr, 0);
        cyc(); #1;
        chk("p8_d0_wr", d0_wr, 1);
        chk("p8_data", d_data_out, 8'h03);
        repeat (4) cyc();

        // Enable dropped with two words in flight
        cyc();
        load0(6'h11);
        load0(6'h12);
        #1;
        chk("e1_rd", vc0_rd, 1);
        cyc(); #1;
        chk("e2_rd", vc0_rd, 1);
        cyc(); enable = 1'b0; #1;
        chk("e3_rd", vc0_rd, 0);
        chk("e3_d1_wr", d1_wr, 1);
        chk("e3_data", d_data_out, 8'h11);
        chk("e3_idle", idle_out, 0);
        cyc(); load0(6'h07); #1;
        chk("e4_rd", vc0_rd, 0);
        chk("e4_d1_wr", d1_wr, 1);
        chk("e4_data", d_data_out, 8'h12);
        chk("e4_idle", idle_out, 0);
        cyc(); #1;
        chk("e5_idle", idle_out, 1);
        chk("e5_wr", d0_wr | d1_wr, 0);
        chk("e5_rd", vc0_rd, 0);

        // Asynchronous reset mid-burst discards in-flight words
        cyc();
        load0(6'h0A);
        load0(6'h0B);
        load0(6'h0C);
        load0(6'h0D);
        enable = 1'b1;
        #1;
        chk("r0_rd", vc0_rd, 0);
        chk("r0_idle", idle_out, 1);
        cyc(); #1;
        chk("r1_rd", vc0_rd, 1);
        cyc(); #1;
        chk("r2_rd", vc0_rd, 1);
        cyc(); #1;
        chk("r3_rd", vc0_rd, 1);
        chk("r3_d0_wr", d0_wr, 1);
        chk("r3_data", d_data_out, 8'h07);
        #2 reset_L = 1'b0;
        #1;
        chk("ra_rd", vc0_rd, 0);
        chk("ra_wr", d0_wr | d1_wr, 0);
        chk("ra_data", d_data_out, 0);
        chk("ra_idle", idle_out, 1);
        cyc(); #1;
        chk("r4_wr", d0_wr | d1_wr, 0);
        chk("r4_rd", vc0_rd, 0);
        reset_L = 1'b1;
        cyc(); #1;
        chk("r5_rd", vc0_rd, 1);
        chk("r5_wr", d0_wr | d1_wr, 0);
        cyc(); #1;
        chk("r6_rd", vc0_rd, 1);
        chk("r6_wr", d0_wr | d1_wr, 0);
        cyc(); #1;
        chk("r7_d0_wr", d0_wr, 1);
        chk("r7_data", d_data_out, 8'h0B);
        cyc(); #1;
        chk("r8_data", d_data_out, 8'h0C);
        cyc(); #1;
        chk("r9_data", d_data_out, 8'h0D);
        repeat (2) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
